// File: rtl/exc_commit_if.sv
// Exception/ERET commit bus between the pipeline side and the commit controller.
// The slave modport is the controller's view. The master modport is the pipeline/CP0 view.
interface exc_commit_if #(
    parameter int PC_W = 32
);
    // Pipeline control and fetch boundary
    logic            pipe_adv;
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic            if_bd;

    // Decode results for the instruction in ID
    logic            id_ri;
    logic            id_sys;
    logic            id_bp;
    logic            id_eret;

    // Execute-stage faults
    logic            ex_ov;
    logic            ex_adel;
    logic            ex_ades;
    logic [PC_W-1:0] ex_badvaddr;

    // CP0 status inputs
    logic            interupt;
    logic            CP0_STATUS_EXL;
    logic [PC_W-1:0] return_addr;

    // Commit outputs toward CP0
    logic            execption;
    logic            ret;
    logic [4:0]      CP0_CAUSE_ExcCode;
    logic [PC_W-1:0] CP0_EPC;
    logic            CP0_STATUS_BD;
    logic [PC_W-1:0] CP0_BadVaddr;

    // Front-end control outputs
    logic            wb_cancel;
    logic            flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    modport slave (
        input  pipe_adv, if_valid, if_pc, if_bd,
        input  id_ri, id_sys, id_bp, id_eret,
        input  ex_ov, ex_adel, ex_ades, ex_badvaddr,
        input  interupt, CP0_STATUS_EXL, return_addr,
        output execption, ret, CP0_CAUSE_ExcCode, CP0_EPC, CP0_STATUS_BD, CP0_BadVaddr,
        output wb_cancel, flush, redirect_valid, redirect_pc
    );

    modport master (
        output pipe_adv, if_valid, if_pc, if_bd,
        output id_ri, id_sys, id_bp, id_eret,
        output ex_ov, ex_adel, ex_ades, ex_badvaddr,
        output interupt, CP0_STATUS_EXL, return_addr,
        input  execption, ret, CP0_CAUSE_ExcCode, CP0_EPC, CP0_STATUS_BD, CP0_BadVaddr,
        input  wb_cancel, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET collector that sits just upstream of the CP0 register file.
// It carries exception info for each instruction through ID -> EX -> MEM.
// The exception is resolved when the instruction commits out of MEM.
// After a commit, the front end gets a one-cycle flush and redirect.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_NORMAL | pipeline running; an exc/eret leaving MEM fires a commit pulse
//   S_FLUSH  | one cycle: flush + redirect driven, all stage valids cleared
//
// The CP0 "return" pulse is carried on bus.ret, because "return" is a keyword.
module exc_commit_ctrl #(
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] EXC_VEC = 32'hbfc00380
) (
    input logic         clk,
    input logic         rstn,
    exc_commit_if.slave bus
);

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef struct packed {
        logic            valid;
        logic            exc;
        logic [4:0]      code;
        logic [PC_W-1:0] pc;
        logic            bd;
        logic [PC_W-1:0] badvaddr;
        logic            eret;
    } stage_t;

    typedef enum logic {S_NORMAL, S_FLUSH} state_t;

    state_t          state_q;
    logic            flush_q;
    logic            redir_valid_q;
    logic [PC_W-1:0] redir_pc_q;

    stage_t id_q, id_d;
    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;

    logic commit_any;
    logic exc_commit;
    logic ret_commit;

    // A commit happens only when MEM advances out while in NORMAL. An exception takes priority over ERET.
    always_comb begin
        commit_any = (state_q == S_NORMAL) && mem_q.valid && bus.pipe_adv
                     && (mem_q.exc || mem_q.eret);
        exc_commit = commit_any && mem_q.exc;
        ret_commit = commit_any && !mem_q.exc;
    end

    // Next values for the stage registers: flushed in FLUSH, held on a stall, otherwise advance and collect exceptions.
    always_comb begin
        id_d  = id_q;
        ex_d  = ex_q;
        mem_d = mem_q;
        if (state_q == S_FLUSH) begin
            id_d  = '0;
            ex_d  = '0;
            mem_d = '0;
        end else if (bus.pipe_adv) begin
            id_d       = '0;
            id_d.valid = bus.if_valid;
            id_d.pc    = bus.if_pc;
            id_d.bd    = bus.if_bd;
            if (bus.if_valid && (bus.if_pc[1:0] != 2'b00)) begin
                id_d.exc      = 1'b1;
                id_d.code     = CODE_ADEL;
                id_d.badvaddr = bus.if_pc;
            end

            ex_d      = id_q;
            ex_d.eret = id_q.valid && bus.id_eret;
            if (id_q.valid && !id_q.exc) begin
                if (bus.interupt && !bus.CP0_STATUS_EXL) begin
                    ex_d.exc  = 1'b1;
                    ex_d.code = CODE_INT;
                end else if (bus.id_ri) begin
                    ex_d.exc  = 1'b1;
                    ex_d.code = CODE_RI;
                end else if (bus.id_sys) begin
                    ex_d.exc  = 1'b1;
                    ex_d.code = CODE_SYS;
                end else if (bus.id_bp) begin
                    ex_d.exc  = 1'b1;
                    ex_d.code = CODE_BP;
                end
            end

            mem_d = ex_q;
            if (ex_q.valid && !ex_q.exc) begin
                if (bus.ex_ov) begin
                    mem_d.exc  = 1'b1;
                    mem_d.code = CODE_OV;
                end else if (bus.ex_adel) begin
                    mem_d.exc      = 1'b1;
                    mem_d.code     = CODE_ADEL;
                    mem_d.badvaddr = bus.ex_badvaddr;
                end else if (bus.ex_ades) begin
                    mem_d.exc      = 1'b1;
                    mem_d.code     = CODE_ADES;
                    mem_d.badvaddr = bus.ex_badvaddr;
                end
            end
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q  <= '0;
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            id_q  <= id_d;
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    // NORMAL/FLUSH sequencer. The registered flush/redirect outputs are valid only in the FLUSH cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_NORMAL;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            case (state_q)
                S_NORMAL: begin
                    if (commit_any) begin
                        state_q       <= S_FLUSH;
                        flush_q       <= 1'b1;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= exc_commit ? EXC_VEC : bus.return_addr;
                    end
                end
                default: begin
                    state_q       <= S_NORMAL;
                    flush_q       <= 1'b0;
                    redir_valid_q <= 1'b0;
                    redir_pc_q    <= '0;
                end
            endcase
        end
    end

    // Commit outputs toward CP0. They are zero outside the commit cycle.
    always_comb begin
        bus.execption         = exc_commit;
        bus.ret               = ret_commit;
        bus.wb_cancel         = exc_commit || ret_commit;
        bus.CP0_CAUSE_ExcCode = exc_commit ? mem_q.code : 5'h00;
        bus.CP0_STATUS_BD     = exc_commit && mem_q.bd;
        bus.CP0_EPC           = '0;
        bus.CP0_BadVaddr      = '0;
        if (exc_commit) begin
            bus.CP0_EPC      = mem_q.bd ? (mem_q.pc - PC_STEP) : mem_q.pc;
            bus.CP0_BadVaddr = mem_q.badvaddr;
        end
        bus.flush          = flush_q;
        bus.redirect_valid = redir_valid_q;
        bus.redirect_pc    = redir_pc_q;
    end

endmodule
